// File: rtl/sprite_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sprite_cmd_pkg
// Shared definitions for the sprite frame sequencer: command-word field
// positions, info-field codes, the drain FSM state type and helpers that
// build the words broadcast to the display components.
// -----------------------------------------------------------------------------
package sprite_cmd_pkg;

  localparam int CMD_W      = 32;
  localparam int INFO_MSB   = 20;
  localparam int INFO_LSB   = 17;
  localparam int PP_SEL_BIT = 13;

  localparam logic [3:0] INFO_IDLE  = 4'b0000;
  localparam logic [3:0] INFO_WRITE = 4'b0001;
  localparam logic [3:0] INFO_FLUSH = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VB
  } drain_state_t;

  // A word whose info field is all ones is a commit marker.
  function automatic logic is_commit(input logic [CMD_W-1:0] w);
    return (w[INFO_MSB:INFO_LSB] == INFO_FLUSH);
  endfunction

  // State write: info forced to WRITE, pp_selc points at the back buffer.
  function automatic logic [CMD_W-1:0] make_write(input logic [CMD_W-1:0] w,
                                                  input logic back_buf);
    logic [CMD_W-1:0] r;
    r = w;
    r[INFO_MSB:INFO_LSB] = INFO_WRITE;
    r[PP_SEL_BIT]        = back_buf;
    return r;
  endfunction

  // Flush: every field zero except info=FLUSH and the buffer being promoted.
  function automatic logic [CMD_W-1:0] make_flush(input logic back_buf);
    logic [CMD_W-1:0] r;
    r = '0;
    r[INFO_MSB:INFO_LSB] = INFO_FLUSH;
    r[PP_SEL_BIT]        = back_buf;
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous first-word-fall-through FIFO. The head entry is read straight
// out of the register array so a word written at one edge is visible on
// o_head right after that edge.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   i_push       write i_data (ignored while full)
//   i_pop        drop the head entry (ignored while empty)
//   o_head       current head entry
//   o_count      number of stored entries (0..DEPTH)
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_frame_sequencer
// Buffers Avalon command writes and replays them one per cycle onto the
// broadcast command bus of the display components. Commit markers are held
// at the FIFO head until vertical blank, then issued as the ping-pong flush
// (at most one per frame), so a frame is never shown half-updated.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   chipselect, write,    Avalon slave; address 0 = command port,
//   read, address,          address 1 = status port
//   writedata, readdata
//   waitrequest           FIFO full, master must hold its write
//   vcount                VGA line counter
//   cmd_out               registered broadcast command word
//   front_buf             buffer currently on screen
// -----------------------------------------------------------------------------
module sprite_frame_sequencer
  import sprite_cmd_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter logic [9:0] V_ACTIVE = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  w_head;
  logic [CW-1:0] w_count;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_head_commit;
  logic         w_vblank_ok;
  logic [4:0]   w_count5;
  logic [31:0]  w_status;
  drain_state_t w_state;

  logic [31:0]  r_cmd_out;
  logic         r_front_buf;
  logic [31:0]  r_readdata;
  logic         r_frame_done;
  logic [15:0]  r_frame_cnt;
  logic [CW-1:0] r_commit_cnt;

  cmd_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (writedata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign waitrequest   = w_full;
  assign w_push        = chipselect && write && !address && !w_full;
  assign w_head_commit = is_commit(w_head);
  assign w_vblank_ok   = (vcount >= V_ACTIVE) && !r_frame_done;
  assign w_count5      = 5'(w_count);
  assign w_status      = {r_frame_cnt, r_front_buf, (r_commit_cnt != '0), 9'h0, w_count5};

  // The drain state is a pure decode of the FIFO head: the head word itself
  // is the state, so a separate state register would only add a cycle.
  always_comb begin
    w_state = ST_IDLE;
    if (!w_empty) begin
      w_state = w_head_commit ? ST_WAIT_VB : ST_ISSUE;
    end
  end

  assign w_pop = (w_state == ST_ISSUE) || ((w_state == ST_WAIT_VB) && w_vblank_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_out    <= '0;
      r_front_buf  <= 1'b0;
      r_readdata   <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_commit_cnt <= '0;
    end else begin
      // Leaving vblank re-arms the one-commit-per-frame limit.
      if (vcount < V_ACTIVE) begin
        r_frame_done <= 1'b0;
      end

      case (w_state)
        ST_ISSUE: begin
          r_cmd_out <= make_write(w_head, ~r_front_buf);
        end
        ST_WAIT_VB: begin
          if (w_vblank_ok) begin
            r_cmd_out    <= make_flush(~r_front_buf);
            r_front_buf  <= ~r_front_buf;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
          end else begin
            r_cmd_out <= '0;
          end
        end
        default: begin
          r_cmd_out <= '0;
        end
      endcase

      // Commits currently anywhere in the FIFO.
      case ({w_push && is_commit(writedata), w_pop && w_head_commit})
        2'b10:   r_commit_cnt <= r_commit_cnt + CW'(1);
        2'b01:   r_commit_cnt <= r_commit_cnt - CW'(1);
        default: r_commit_cnt <= r_commit_cnt;
      endcase

      if (chipselect && read) begin
        r_readdata <= address ? w_status : 32'h0;
      end
    end
  end

  assign cmd_out   = r_cmd_out;
  assign front_buf = r_front_buf;
  assign readdata  = r_readdata;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sprite_frame_sequencer
// Directed stimulus with a scoreboard: every write that should reach the
// command bus pushes its hand-computed broadcast word into a queue; a monitor
// pops and compares each non-zero cmd_out, optionally checking the cycle.
// -----------------------------------------------------------------------------
module tb_sprite_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        address = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [9:0]  vcount = 10'd0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] cmd_out;
  logic        front_buf;

  // mode: 0 = any cycle, 1 = exact cycle in cyc, 2 = cycle held in flush_cyc
  typedef struct {
    logic [31:0] word;
    int          mode;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_want;
  int   cyc = 0;
  int   flush_cyc = -1;
  int   n_checks = 0;
  int   n_fail = 0;

  sprite_frame_sequencer #(
    .DEPTH    (16),
    .V_ACTIVE (10'd480)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .vcount      (vcount),
    .cmd_out     (cmd_out),
    .front_buf   (front_buf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds the write under waitrequest, bounded.
  task automatic avl_write(input logic [31:0] d, input logic [31:0] e, input int mode,
                           input bit has_exp, output int acc_edge);
    exp_t ent;
    bit   acc;
    acc      = 1'b0;
    acc_edge = -1;
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 1'b0;
    writedata  = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      if (!waitrequest) begin
        acc      = 1'b1;
        acc_edge = cyc + 1;
        if (has_exp) begin
          ent.word = e;
          ent.mode = mode;
          ent.cyc  = cyc + 2;
          exp_q.push_back(ent);
        end
      end
      @(negedge clk);
    end
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'h0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_accept: write %h never accepted, required acceptance", d);
    end else begin
      $display("wr   %h accepted at edge %0d", d, acc_edge);
    end
  endtask

  task automatic wr(input logic [31:0] d, input logic [31:0] e, input int mode);
    int dummy;
    avl_write(d, e, mode, 1'b1, dummy);
  endtask

  task automatic wr_noexp(input logic [31:0] d);
    int dummy;
    avl_write(d, 32'h0, 0, 1'b0, dummy);
  endtask

  task automatic read_status(output logic [31:0] v);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 1'b1;
    @(negedge clk);
    v          = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
    address    = 1'b0;
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (cmd_out !== 32'h0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL cmd_unexpected: got %h at cycle %0d, required no command", cmd_out, cyc);
            end else begin
              mon_e = exp_q.pop_front();
              mon_want = (mon_e.mode == 1) ? mon_e.cyc : ((mon_e.mode == 2) ? flush_cyc : cyc);
              if (cmd_out !== mon_e.word || cyc != mon_want) begin
                n_fail++;
                $display("FAIL cmd_out: got %h at cycle %0d, required %h at cycle %0d",
                         cmd_out, cyc, mon_e.word, mon_want);
              end else begin
                $display("cmd  %h at cycle %0d", cmd_out, cyc);
              end
            end
          end
        end
      end
      begin : stimulus
        logic [31:0] st;
        int acc_e;
        int rel_c;
        acc_e = -1;
        rel_c = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_out", cmd_out, 32'h0);
        chk("reset_front_buf", {31'b0, front_buf}, 32'h0);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
        reset = 1'b0;
        tick(1);
        read_status(st);
        chk("status_after_reset", st, 32'h0);

        // Single state write, exact two-stage latency
        wr(32'h40208064, 32'h4022A064, 1);
        tick(4);
        read_status(st);
        chk("status_idle", st, 32'h0);

        // Three state writes then a commit, held until vblank
        vcount = 10'd100;
        wr(32'h04000001, 32'h04022001, 1);
        wr(32'h0816A005, 32'h0802A005, 1);
        wr(32'hFFE1FFFF, 32'hFFE3FFFF, 1);
        wr(32'hABFFFFFF, 32'h001E2000, 2);
        tick(4);
        read_status(st);
        chk("status_commit_pending", st, 32'h00004001);
        chk("front_before_vblank", {31'b0, front_buf}, 32'h0);
        vcount = 10'd480;
        flush_cyc = cyc + 1;
        tick(3);
        chk("front_after_flush1", {31'b0, front_buf}, 32'h1);
        read_status(st);
        chk("status_after_flush1", st, 32'h00018000);
        vcount = 10'd100;
        tick(2);

        // Two commits in one frame, state write behind the first
        wr(32'h001E0000, 32'h001E0000, 2);
        wr(32'h00000123, 32'h00022123, 0);
        wr(32'h001E0000, 32'h001E2000, 2);
        tick(2);
        vcount = 10'd480;
        flush_cyc = cyc + 1;
        tick(6);
        read_status(st);
        chk("status_second_commit_held", st, 32'h00024001);
        vcount = 10'd100;
        tick(2);
        vcount = 10'd480;
        flush_cyc = cyc + 1;
        tick(3);
        read_status(st);
        chk("status_after_flush3", st, 32'h00038000);
        vcount = 10'd100;
        tick(2);

        // Fill FIFO behind a commit, 17th write held until the first pop
        wr(32'h001E0000, 32'h001E0000, 2);
        for (int i = 1; i <= 15; i++) begin
          wr(32'(i), 32'h00022000 | 32'(i), 0);
        end
        tick(1);
        chk("full_waitrequest", {31'b0, waitrequest}, 32'h1);
        read_status(st);
        chk("status_full", st, 32'h0003C010);
        fork
          begin
            avl_write(32'h00000011, 32'h00022011, 0, 1'b1, acc_e);
          end
          begin
            tick(3);
            chk("write_held", {31'b0, waitrequest}, 32'h1);
            vcount = 10'd480;
            flush_cyc = cyc + 1;
            rel_c = cyc;
          end
        join
        chk("held_write_accept_edge", 32'(acc_e), 32'(rel_c + 2));
        tick(25);
        read_status(st);
        chk("status_after_drain", st, 32'h00040000);
        vcount = 10'd100;
        tick(2);

        // Reset with queued words and a pending commit
        wr(32'h001E0000, 32'h001E2000, 2);
        tick(2);
        vcount = 10'd480;
        flush_cyc = cyc + 1;
        tick(3);
        chk("front_before_reset", {31'b0, front_buf}, 32'h1);
        vcount = 10'd100;
        tick(2);
        wr_noexp(32'hABFFFFFF);
        wr_noexp(32'h00000031);
        wr_noexp(32'h00000032);
        wr_noexp(32'h00000033);
        wr_noexp(32'h00000034);
        tick(1);
        read_status(st);
        chk("status_before_reset", st, 32'h0005C005);
        reset = 1'b1;
        tick(1);
        chk("midreset_cmd_out", cmd_out, 32'h0);
        chk("midreset_front_buf", {31'b0, front_buf}, 32'h0);
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_waitrequest", {31'b0, waitrequest}, 32'h0);
        reset = 1'b0;
        vcount = 10'd480;
        tick(10);
        read_status(st);
        chk("status_after_midreset", st, 32'h0);
        wr(32'h00000055, 32'h00022055, 1);
        tick(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join_any
  end

endmodule
